// File: rtl/uart_pkg.sv
// Constants and FSM state encoding shared by the UART transmitter and receiver.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
    localparam int unsigned BAUD_DEFAULT     = 115_200;

    // 8N1 frame: one start bit, eight data bits, one stop bit.
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_START = 2'd1;
    localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;
    localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

    function automatic int unsigned bit_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the transmitter: power-of-two depth, occupancy counter,
// registered full/empty flags and a combinational head-of-queue read.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo: DEPTH must be a power of two in 2..16");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;

    // A write while full is dropped even if the same cycle frees an entry.
    assign w_push = wr && !r_full && !rst;
    assign w_pop  = rd && !r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = CNT_W'(r_count + 1'b1);
            2'b01:   w_count_next = CNT_W'(r_count - 1'b1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= PTR_W'(r_wptr + 1'b1);
            end
            if (w_pop) begin
                r_rptr <= PTR_W'(r_rptr + 1'b1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    assign dout  = r_mem[r_rptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffered byte input, bit-period counter and shift register
// driving a registered, idle-high serial line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int unsigned BAUD       = BAUD_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr,
    output logic                 full,
    output logic                 busy,
    output logic                 tx
);

    localparam int unsigned DIV   = bit_div(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_next;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     w_bit_cnt_next;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [IDX_W-1:0]     w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_busy;
    logic                 w_bit_end;
    logic                 w_pop;
    logic                 w_accept;

    logic [DATA_BITS-1:0] w_fifo_dout;
    logic [OCC_W-1:0]     w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .din   (din),
        .rd    (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_accept  = wr && !w_fifo_full && !rst;
    assign w_bit_end = (r_bit_cnt == BIT_LAST);

    // Next-state logic; the line value is derived from the next state so tx stays registered.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = (r_state == ST_IDLE || w_bit_end) ? '0 : CNT_W'(r_bit_cnt + 1'b1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = IDX_W'(r_bit_idx + 1'b1);
                    end
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when a byte is waiting.
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            // Going idle implies the buffer was empty, so only a fresh write keeps busy high.
            r_busy    <= (w_state_next != ST_IDLE) || (w_fifo_count != '0) || w_accept;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign full = w_fifo_full;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model checked every cycle, a line decoder,
// a directed vector table and hand-written corner sequences, plus a default-parameter run.
module tb_uart_tx;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    localparam int DIV2  = 868;

    logic       clk = 1'b0;
    logic       rst, wr;
    logic [7:0] din;
    logic       full, busy, tx;
    logic       rst2, wr2;
    logic [7:0] din2;
    logic       full2, busy2, tx2;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .wr(wr), .full(full), .busy(busy), .tx(tx)
    );

    uart_tx dut2 (
        .clk(clk), .rst(rst2), .din(din2), .wr(wr2), .full(full2), .busy(busy2), .tx(tx2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check32(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return at the sampling point (negedge) of cycle c.
    task automatic at_cycle(input int c);
        if (cyc > c) begin
            checks++;
            errors++;
            $display("FAIL at_cycle: cycle %0d already passed, now %0d", c, cyc);
            return;
        end
        while (cyc < c) tick();
        @(negedge clk);
    endtask

    // Line level of an 8N1 frame k bit-periods after its start.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 1 && k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Frame-level model: queue of waiting bytes plus the byte currently on the line.
    logic [7:0] mq[$];
    bit         m_in_frame = 1'b0;
    int         m_start    = 0;
    logic [7:0] m_cur      = 8'h00;

    always @(posedge clk) begin : model_upd
        bit was_full;
        bit do_pop;
        if (rst) begin
            mq.delete();
            m_in_frame = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = 1'b0;
            if (!m_in_frame) begin
                do_pop = (mq.size() != 0);
            end else if (cyc == m_start + 10 * DIV - 1) begin
                if (mq.size() != 0) do_pop = 1'b1;
                else m_in_frame = 1'b0;
            end
            if (do_pop) begin
                m_cur      = mq.pop_front();
                m_in_frame = 1'b1;
                m_start    = cyc + 1;
            end
            if (wr && !was_full) mq.push_back(din);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin : model_cmp
        logic etx;
        if (chk_en) begin
            etx = m_in_frame ? exp_bit(m_cur, (cyc - m_start) / DIV) : 1'b1;
            check32("model tx/busy/full", {29'd0, tx, busy, full},
                    {29'd0, etx, (m_in_frame || mq.size() != 0), (mq.size() == DEPTH)});
        end
    end

    // Line decoder: samples each bit at its centre.
    bit         rx_en = 1'b0;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];

    always begin : decoder
        @(negedge clk);
        if (rx_en && tx === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (DIV) @(negedge clk);
                rx_byte[b] = tx;
            end
            repeat (DIV) @(negedge clk);
            rx_q.push_back(rx_byte);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t       vecs[6];
    int         n;
    int         bad;
    logic [9:0] f2;

    initial begin
        vecs[0] = '{din: 8'h55, frame: 10'b1010101010};
        vecs[1] = '{din: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{din: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{din: 8'hA5, frame: 10'b1101001010};
        vecs[4] = '{din: 8'h01, frame: 10'b1000000010};
        vecs[5] = '{din: 8'h80, frame: 10'b1100000000};
        f2      = 10'b1001000010;

        rst = 1'b1; wr = 1'b0; din = 8'h00;
        rst2 = 1'b1; wr2 = 1'b0; din2 = 8'h00;

        // Reset held three cycles, then a quiet line for 200 cycles.
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check1("reset tx", tx, 1'b1);
        check1("reset busy", busy, 1'b0);
        check1("reset full", full, 1'b0);
        tick(); tick();
        rst = 1'b0; rst2 = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) bad++;
            tick();
        end
        check32("idle line anomalies", bad, 0);

        // Single-byte frames from the table; din changes right after acceptance.
        for (int i = 0; i < 6; i++) begin
            tick();
            wr = 1'b1; din = vecs[i].din; n = cyc;
            tick();
            wr = 1'b0; din = ~vecs[i].din;
            at_cycle(n + 1);
            check1("latency tx still idle", tx, 1'b1);
            check1("busy after write", busy, 1'b1);
            at_cycle(n + 2);
            check1("start bit edge", tx, 1'b0);
            for (int k = 0; k < 10; k++) begin
                at_cycle(n + 2 + k * DIV + DIV / 2);
                check1("frame bit", tx, vecs[i].frame[k]);
            end
            at_cycle(n + 161);
            check1("busy in stop bit", busy, 1'b1);
            at_cycle(n + 162);
            check1("busy low after frame", busy, 1'b0);
        end

        // Back-to-back writes chain frames with no idle gap.
        rx_q.delete();
        rx_en = 1'b1;
        tick();
        wr = 1'b1; din = 8'h48; n = cyc;
        tick();
        din = 8'h0D;
        tick();
        wr = 1'b0;
        at_cycle(n + 161);
        check1("b2b first stop", tx, 1'b1);
        at_cycle(n + 162);
        check1("b2b second start", tx, 1'b0);
        at_cycle(n + 330);
        check1("b2b busy done", busy, 1'b0);
        check32("b2b byte count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check32("b2b byte0", rx_q[0], 8'h48);
            check32("b2b byte1", rx_q[1], 8'h0D);
        end

        // Overflow: six writes, the sixth arrives while full and is dropped.
        rx_q.delete();
        tick();
        n = cyc;
        for (int v = 1; v <= 6; v++) begin
            wr = 1'b1; din = 8'(v);
            tick();
        end
        wr = 1'b0;
        at_cycle(n + 6);
        check1("overflow full", full, 1'b1);
        at_cycle(n + 162);
        check1("overflow full cleared", full, 1'b0);
        at_cycle(n + 2 + 800 + 10);
        check1("overflow busy done", busy, 1'b0);
        check32("overflow byte count", rx_q.size(), 5);
        for (int v = 0; v < 5; v++) begin
            if (v < rx_q.size()) check32("overflow byte", rx_q[v], v + 1);
        end
        rx_en = 1'b0;

        // Reset during data bit 3 of 8'hA5 with two bytes queued.
        tick();
        wr = 1'b1; din = 8'hA5; n = cyc;
        tick();
        din = 8'h3C;
        tick();
        din = 8'hC3;
        tick();
        wr = 1'b0;
        at_cycle(n + 2 + 4 * DIV + 6);
        check1("data bit 3 of A5", tx, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_cycle(n + 2 + 4 * DIV + 7);
        check1("abort tx high", tx, 1'b1);
        check1("abort busy low", busy, 1'b0);
        check1("abort full low", full, 1'b0);
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check32("frames after abort", bad, 0);

        // Random traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            din = 8'($urandom);
        end
        tick();
        rst = 1'b0; wr = 1'b0;
        bad = 0;
        while (busy === 1'b1 && bad < 1500) begin
            tick();
            bad++;
        end
        @(negedge clk);
        check1("random drain idle", busy, 1'b0);

        // Default parameters: 868-cycle bits, 8680-cycle frame.
        tick();
        wr2 = 1'b1; din2 = 8'h21; n = cyc;
        tick();
        wr2 = 1'b0; din2 = 8'h00;
        at_cycle(n + 1);
        check1("dflt latency tx idle", tx2, 1'b1);
        check1("dflt busy", busy2, 1'b1);
        for (int k = 0; k < 10; k++) begin
            at_cycle(n + 2 + k * DIV2);
            check1("dflt bit first cycle", tx2, f2[k]);
            if (k < 9) begin
                at_cycle(n + 2 + k * DIV2 + DIV2 - 1);
                check1("dflt bit last cycle", tx2, f2[k]);
            end
        end
        at_cycle(n + 2 + 10 * DIV2 - 1);
        check1("dflt stop last cycle", tx2, 1'b1);
        check1("dflt busy last cycle", busy2, 1'b1);
        at_cycle(n + 2 + 10 * DIV2);
        check1("dflt busy after frame", busy2, 1'b0);
        check1("dflt full", full2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning byte buffer entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port din  input  8  byte to transmit.
REQ-007 SHALL have port wr  input  1  write strobe; din is captured on a cycle with wr=1 and full=0.
REQ-008 SHALL have port full  output  1  buffer holds FIFO_DEPTH bytes.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress or the buffer is non-empty.
REQ-010 SHALL have port tx  output  1  serial line, registered, idle high.

Function
REQ-011 SHALL use bit period DIV = CLK_FREQ/BAUD cycles (integer division; 868 at defaults); DIV < 2 is a parameter error.
REQ-012 SHALL emit 8N1 frames: start bit 0, data bits LSB first, stop bit 1; each bit exactly DIV cycles; frame = 10*DIV cycles.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1; if buffer non-empty, pop head into the shift register and go to START.
REQ-015 START: tx=0 for DIV cycles, then go to DATA with bit index 0.
REQ-016 DATA: tx=shift[0] for DIV cycles per bit; shift right after each bit; after bit index 7 go to STOP.
REQ-017 STOP: tx=1 for DIV cycles; on completion, if buffer non-empty, pop and go directly to START (no idle cycle), else go to IDLE.
REQ-018 Latency: with FSM in IDLE and buffer empty, wr=1 in cycle N SHALL drive tx low from cycle N+2.
REQ-019 Buffer write SHALL occur on wr=1 with full=0; wr=1 with full=1 SHALL be ignored (byte dropped, no state change), even if a pop occurs in the same cycle.
REQ-020 A simultaneous write and pop with full=0 SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-021 Occupancy counter, read and write pointers SHALL wrap modulo FIFO_DEPTH; full = (count == FIFO_DEPTH).
REQ-022 busy SHALL be high when state != IDLE or count != 0, and low otherwise.
REQ-023 The bit-period counter SHALL count 0..DIV-1, reload to 0 on each bit boundary, and be held at 0 in IDLE.
REQ-024 din SHALL be sampled only in the accepting cycle; later changes to din SHALL not affect a buffered byte.

Reset
REQ-025 rst=1 SHALL force, by the next edge: state IDLE, tx=1, busy=0, full=0, count=0, pointers=0, bit counter=0, shift register=0.
REQ-026 rst asserted mid-frame SHALL abort the frame (tx high from the cycle after rst is sampled) and discard all buffered bytes.
REQ-027 wr SHALL be ignored in any cycle where rst=1.

Structure
REQ-028 Package uart_pkg SHALL hold the default CLK_FREQ and BAUD constants, the 8N1 frame-length constant (10), and the FSM state encoding, shared with the UART receiver.
REQ-029 The byte buffer SHALL be a sub-module uart_tx_fifo (ports: clk, rst, wr, din, rd, dout, count, full, empty); the FSM, bit counter and shift register stay in uart_tx.

Verification (CLK_FREQ=16, BAUD=1, DIV=16 unless stated)
REQ-030 Reset idle: hold rst for 3 cycles, then release with wr=0 for 200 cycles -> tx=1, busy=0, full=0 throughout.
REQ-031 Single byte: wr=1 with din=8'h55 in cycle N -> tx=0 during cycles N+2..N+17, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, stop high 16 cycles; busy low at cycle N+162.
REQ-032 Back-to-back: write 8'h48 and 8'h0D on consecutive cycles -> second start bit begins exactly 160 cycles after the first; tx never stays high beyond the stop bit between frames.
REQ-033 Overflow: write 8'h01..8'h06 on 6 consecutive cycles with FSM idle -> 8'h01 popped, 8'h02..8'h05 buffered, full=1, 8'h06 dropped; line carries 01,02,03,04,05 only.
REQ-034 Reset mid-frame: assert rst during data bit 3 of 8'hA5 with 2 bytes buffered -> tx=1 from the next cycle, busy=0, full=0; no further frames transmitted.
REQ-035 Default parameters: CLK_FREQ=100000000, BAUD=115200, send 8'h21 -> each bit lasts 868 cycles, frame 8680 cycles.
